// File: rtl/tia_playfield_sequencer_if.sv
// rtl/tia_playfield_sequencer_if.sv - scan control, register write and pixel output bundle for the playfield sequencer
interface tia_playfield_sequencer_if;
   logic       en;
   logic       line_start;
   logic       wr;
   logic [1:0] addr;
   logic [7:0] data;
   logic       pf;
   logic       side;
   logic       hblank;
   logic [7:0] hcount;

   modport master (
      output en, line_start, wr, addr, data,
      input  pf, side, hblank, hcount
   );

   modport slave (
      input  en, line_start, wr, addr, data,
      output pf, side, hblank, hcount
   );
endinterface

// File: rtl/tia_playfield_sequencer.sv
// rtl/tia_playfield_sequencer.sv - TIA playfield registers, color-clock counter and serial pixel selector
module tia_playfield_sequencer #(
   parameter int LINE_CLOCKS   = 228,
   parameter int HBLANK_CLOCKS = 68
) (
   input logic                      clk,
   input logic                      rl,
   tia_playfield_sequencer_if.slave bus
);
   localparam logic [7:0] LAST_H  = 8'(LINE_CLOCKS - 1);
   localparam logic [7:0] BLANK_H = 8'(HBLANK_CLOCKS);
   localparam logic [7:0] LATCH_H = 8'(HBLANK_CLOCKS + 80);

   logic [7:0]  hcount_q, hcount_d;
   logic [3:0]  pf0_q, pf0_d;
   logic [7:0]  pf1_q, pf1_d;
   logic [7:0]  pf2_q, pf2_d;
   logic        ctrl_q, ctrl_d;
   logic        reflect_q, reflect_d;
   logic        pf_q, pf_d;
   logic        side_q, side_d;
   logic        hblank_q, hblank_d;

   logic [7:0]  hnext;
   logic        hblank_next;
   logic [5:0]  b;
   logic [4:0]  idx;
   logic [31:0] field;

   // Register writes ignore en so the CPU can update playfield data during any clock.
   always_comb begin
      pf0_d  = pf0_q;
      pf1_d  = pf1_q;
      pf2_d  = pf2_q;
      ctrl_d = ctrl_q;
      if (bus.wr) begin
         unique case (bus.addr)
            2'd0:    pf0_d  = bus.data[7:4];
            2'd1:    pf1_d  = bus.data;
            2'd2:    pf2_d  = bus.data;
            default: ctrl_d = bus.data[0];
         endcase
      end
   end

   always_comb begin
      if (bus.line_start || hcount_q == LAST_H) begin
         hnext = '0;
      end else begin
         hnext = hcount_q + 8'd1;
      end
      hblank_next = (hnext < BLANK_H);
      b           = 6'((hnext - BLANK_H) >> 2);

      reflect_d = reflect_q;
      if (bus.en && hnext == LATCH_H) begin
         reflect_d = ctrl_q;
      end

      if (b < 6'd20) begin
         idx = b[4:0];
      end else if (reflect_d) begin
         idx = 5'(6'd39 - b);
      end else begin
         idx = 5'(b - 6'd20);
      end

      // Playfield bits laid out in scan order: PF0 4..7, PF1 7..0, PF2 0..7.
      field = {12'd0, pf2_q,
               pf1_q[0], pf1_q[1], pf1_q[2], pf1_q[3],
               pf1_q[4], pf1_q[5], pf1_q[6], pf1_q[7],
               pf0_q};

      hcount_d = hcount_q;
      pf_d     = pf_q;
      side_d   = side_q;
      hblank_d = hblank_q;
      if (bus.en) begin
         hcount_d = hnext;
         hblank_d = hblank_next;
         side_d   = ~hblank_next & (b >= 6'd20);
         pf_d     = ~hblank_next & field[idx];
      end
   end

   always_ff @(posedge clk or negedge rl) begin
      if (!rl) begin
         hcount_q  <= '0;
         pf0_q     <= '0;
         pf1_q     <= '0;
         pf2_q     <= '0;
         ctrl_q    <= 1'b0;
         reflect_q <= 1'b0;
         pf_q      <= 1'b0;
         side_q    <= 1'b0;
         hblank_q  <= 1'b1;
      end else begin
         hcount_q  <= hcount_d;
         pf0_q     <= pf0_d;
         pf1_q     <= pf1_d;
         pf2_q     <= pf2_d;
         ctrl_q    <= ctrl_d;
         reflect_q <= reflect_d;
         pf_q      <= pf_d;
         side_q    <= side_d;
         hblank_q  <= hblank_d;
      end
   end

   assign bus.pf     = pf_q;
   assign bus.side   = side_q;
   assign bus.hblank = hblank_q;
   assign bus.hcount = hcount_q;
endmodule

// File: tb/tb_tia_playfield_sequencer.sv
// tb/tb_tia_playfield_sequencer.sv - directed self-checking bench for tia_playfield_sequencer
module tb_tia_playfield_sequencer;
   logic clk = 1'b0;
   logic rl;

   tia_playfield_sequencer_if bus ();

   tia_playfield_sequencer dut (
      .clk (clk),
      .rl  (rl),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
      bus.en   = 1'b0;
      bus.wr   = 1'b1;
      bus.addr = a;
      bus.data = d;
      tick();
      bus.wr   = 1'b0;
      bus.en   = 1'b1;
   endtask

   task automatic goto_h(input int h);
      int n;
      n = 0;
      bus.en = 1'b1;
      while (bus.hcount != 8'(h) && n < 300) begin
         tick();
         n++;
      end
      n_cmp++;
      if (bus.hcount !== 8'(h)) begin
         n_bad++;
         $display("FAIL goto_h: hcount=%0d required %0d", bus.hcount, h);
      end
   endtask

   task automatic test_reset();
      rl             = 1'b0;
      bus.en         = 1'b0;
      bus.line_start = 1'b0;
      bus.wr         = 1'b0;
      bus.addr       = 2'd0;
      bus.data       = 8'd0;
      repeat (3) tick();
      n_cmp += 4;
      if (bus.pf !== 1'b0) begin n_bad++; $display("FAIL reset_pf: got %b want 0", bus.pf); end
      if (bus.side !== 1'b0) begin n_bad++; $display("FAIL reset_side: got %b want 0", bus.side); end
      if (bus.hblank !== 1'b1) begin n_bad++; $display("FAIL reset_hblank: got %b want 1", bus.hblank); end
      if (bus.hcount !== 8'd0) begin n_bad++; $display("FAIL reset_hcount: got %0d want 0", bus.hcount); end
      rl = 1'b1;
   endtask

   task automatic test_blank_line();
      bus.en = 1'b1;
      for (int i = 0; i < 228; i++) begin
         int h;
         tick();
         h = (i + 1) % 228;
         n_cmp += 4;
         if (bus.hcount !== 8'(h)) begin n_bad++; $display("FAIL blank_hcount: got %0d want %0d", bus.hcount, h); end
         if (bus.pf !== 1'b0) begin n_bad++; $display("FAIL blank_pf h=%0d: got %b want 0", h, bus.pf); end
         if (bus.hblank !== (h < 68)) begin n_bad++; $display("FAIL blank_hblank h=%0d: got %b want %b", h, bus.hblank, h < 68); end
         if (bus.side !== (h >= 148)) begin n_bad++; $display("FAIL blank_side h=%0d: got %b want %b", h, bus.side, h >= 148); end
      end
   endtask

   task automatic test_pf0_noreflect();
      wr_reg(2'd0, 8'h10);
      wr_reg(2'd1, 8'h00);
      wr_reg(2'd2, 8'h00);
      wr_reg(2'd3, 8'h00);
      goto_h(227);
      for (int h = 0; h < 228; h++) begin
         logic exp_pf;
         tick();
         exp_pf = (h >= 68 && h <= 71) || (h >= 148 && h <= 151);
         n_cmp += 2;
         if (bus.pf !== exp_pf) begin n_bad++; $display("FAIL pf0_noreflect h=%0d: got %b want %b", h, bus.pf, exp_pf); end
         if (bus.side !== (h >= 148)) begin n_bad++; $display("FAIL pf0_side h=%0d: got %b want %b", h, bus.side, h >= 148); end
      end
   endtask

   task automatic test_pf0_reflect();
      wr_reg(2'd3, 8'h01);
      goto_h(227);
      for (int h = 0; h < 228; h++) begin
         logic exp_pf;
         tick();
         exp_pf = (h >= 68 && h <= 71) || (h >= 224 && h <= 227);
         n_cmp++;
         if (bus.pf !== exp_pf) begin n_bad++; $display("FAIL pf0_reflect h=%0d: got %b want %b", h, bus.pf, exp_pf); end
      end
   endtask

   task automatic test_pf1_pf2();
      wr_reg(2'd0, 8'h0F);
      wr_reg(2'd1, 8'h80);
      wr_reg(2'd2, 8'h80);
      wr_reg(2'd3, 8'hFE);
      goto_h(227);
      for (int h = 0; h < 228; h++) begin
         logic exp_pf;
         tick();
         exp_pf = (h >= 84 && h <= 87) || (h >= 144 && h <= 147) ||
                  (h >= 164 && h <= 167) || (h >= 224 && h <= 227);
         n_cmp++;
         if (bus.pf !== exp_pf) begin n_bad++; $display("FAIL pf1_pf2 h=%0d: got %b want %b", h, bus.pf, exp_pf); end
      end
   endtask

   task automatic test_late_reflect();
      wr_reg(2'd0, 8'h10);
      wr_reg(2'd1, 8'h00);
      wr_reg(2'd2, 8'h00);
      wr_reg(2'd3, 8'h00);
      goto_h(227);
      for (int line = 0; line < 2; line++) begin
         for (int h = 0; h < 228; h++) begin
            logic exp_pf;
            tick();
            if (line == 0)
               exp_pf = (h >= 68 && h <= 71) || (h >= 148 && h <= 151);
            else
               exp_pf = (h >= 68 && h <= 71) || (h >= 224 && h <= 227);
            n_cmp++;
            if (bus.pf !== exp_pf) begin n_bad++; $display("FAIL late_reflect line=%0d h=%0d: got %b want %b", line, h, bus.pf, exp_pf); end
            if (line == 0 && h == 150) wr_reg(2'd3, 8'h01);
         end
      end
   endtask

   task automatic test_write_visibility();
      wr_reg(2'd0, 8'h00);
      goto_h(67);
      bus.wr   = 1'b1;
      bus.addr = 2'd0;
      bus.data = 8'h10;
      tick();
      bus.wr   = 1'b0;
      n_cmp += 2;
      if (bus.hcount !== 8'd68) begin n_bad++; $display("FAIL wvis_hcount: got %0d want 68", bus.hcount); end
      if (bus.pf !== 1'b0) begin n_bad++; $display("FAIL wvis_old: got %b want 0", bus.pf); end
      tick();
      n_cmp++;
      if (bus.pf !== 1'b1) begin n_bad++; $display("FAIL wvis_new: got %b want 1", bus.pf); end
   endtask

   task automatic test_en_hold();
      bus.en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp += 3;
         if (bus.hcount !== 8'd69) begin n_bad++; $display("FAIL en_hold_hcount: got %0d want 69", bus.hcount); end
         if (bus.pf !== 1'b1) begin n_bad++; $display("FAIL en_hold_pf: got %b want 1", bus.pf); end
         if (bus.hblank !== 1'b0) begin n_bad++; $display("FAIL en_hold_hblank: got %b want 0", bus.hblank); end
      end
      bus.en = 1'b1;
   endtask

   task automatic test_line_start();
      goto_h(100);
      bus.line_start = 1'b1;
      tick();
      n_cmp += 3;
      if (bus.hcount !== 8'd0) begin n_bad++; $display("FAIL ls_mid_hcount: got %0d want 0", bus.hcount); end
      if (bus.hblank !== 1'b1) begin n_bad++; $display("FAIL ls_mid_hblank: got %b want 1", bus.hblank); end
      if (bus.pf !== 1'b0) begin n_bad++; $display("FAIL ls_mid_pf: got %b want 0", bus.pf); end
      tick();
      n_cmp++;
      if (bus.hcount !== 8'd0) begin n_bad++; $display("FAIL ls_at_zero: got %0d want 0", bus.hcount); end
      bus.line_start = 1'b0;
      tick();
      n_cmp++;
      if (bus.hcount !== 8'd1) begin n_bad++; $display("FAIL ls_resume: got %0d want 1", bus.hcount); end
      bus.en         = 1'b0;
      bus.line_start = 1'b1;
      tick();
      bus.en         = 1'b1;
      bus.line_start = 1'b0;
      tick();
      n_cmp++;
      if (bus.hcount !== 8'd2) begin n_bad++; $display("FAIL ls_no_en: got %0d want 2", bus.hcount); end
   endtask

   task automatic test_async_reset();
      wr_reg(2'd0, 8'h00);
      wr_reg(2'd1, 8'hFF);
      goto_h(100);
      n_cmp++;
      if (bus.pf !== 1'b1) begin n_bad++; $display("FAIL ar_pre_pf: got %b want 1", bus.pf); end
      #2;
      rl = 1'b0;
      #1;
      n_cmp += 4;
      if (bus.pf !== 1'b0) begin n_bad++; $display("FAIL ar_pf: got %b want 0", bus.pf); end
      if (bus.hblank !== 1'b1) begin n_bad++; $display("FAIL ar_hblank: got %b want 1", bus.hblank); end
      if (bus.hcount !== 8'd0) begin n_bad++; $display("FAIL ar_hcount: got %0d want 0", bus.hcount); end
      if (bus.side !== 1'b0) begin n_bad++; $display("FAIL ar_side: got %b want 0", bus.side); end
      tick();
      rl = 1'b1;
      tick();
      n_cmp++;
      if (bus.hcount !== 8'd1) begin n_bad++; $display("FAIL ar_restart: got %0d want 1", bus.hcount); end
      goto_h(100);
      n_cmp++;
      if (bus.pf !== 1'b0) begin n_bad++; $display("FAIL ar_regs_cleared: got %b want 0", bus.pf); end
   endtask

   initial begin
      test_reset();
      test_blank_line();
      test_pf0_noreflect();
      test_pf0_reflect();
      test_pf1_pf2();
      test_late_reflect();
      test_write_visibility();
      test_en_hold();
      test_line_start();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/tia_playfield_sequencer.md
Name: tia_playfield_sequencer

Overview:
- Scan controller for the TIA playfield datapath.
- Holds the PF0/PF1/PF2/CTRLPF write registers and runs the horizontal color-clock counter.
- Selects the playfield bit for every visible pixel, including the reflect latch at screen centre.
- Drives the serial playfield output consumed by the TIA color/priority logic, replacing ad-hoc sequencing of the playfield register cells.

Parameters:
- LINE_CLOCKS, 228, color clocks per scanline; hcount wraps LINE_CLOCKS-1 -> 0.
- HBLANK_CLOCKS, 68, blanked clocks at line start; visible pixel p = hcount - HBLANK_CLOCKS.

Ports:
- clk  in  1  master color clock.
- rl  in  1  reset, asynchronous, active-low.
- en  in  1  color-clock enable; counter and outputs advance only on clk rising with en=1.
- line_start  in  1  sampled with en; forces next hcount to 0.
- wr  in  1  register write strobe; honoured on any clk rising edge, independent of en.
- addr  in  2  0=PF0, 1=PF1, 2=PF2, 3=CTRLPF.
- data  in  8  write data.
- pf  out  1  playfield pixel, registered.
- side  out  1  0 = left half, 1 = right half (for score-mode colouring), registered.
- hblank  out  1  1 while hcount < HBLANK_CLOCKS, registered.
- hcount  out  8  current color clock, 0..LINE_CLOCKS-1.

Behaviour:
- Reset (rl=0, async): hcount=0; PF0/PF1/PF2/CTRLPF=0; reflect_active=0; pf=0; side=0; hblank=1. Reset mid-line aborts the line immediately; after release the scan restarts from hcount=0.
- Writes: on clk rising with wr=1, the register selected by addr takes data.
  - PF0 keeps only data[7:4]; the low nibble reads as 0.
  - CTRLPF keeps only data[0] (reflect).
- Write visibility: a write and an en edge in the same cycle -> the pf computed on that edge uses the old register value; the new value is visible from the next en edge.
- Counter update, on en edge: hnext = line_start ? 0 : (hcount==LINE_CLOCKS-1 ? 0 : hcount+1); hcount <= hnext. With en=0, all state holds except the write registers.
- Output registers, on each en edge, computed from hnext:
  - hblank <= (hnext < HBLANK_CLOCKS).
  - p = hnext - HBLANK_CLOCKS; b = p>>2 (0..39).
  - side <= ~hblank_next & (b >= 20).
- Reflect latch: on the en edge where hnext == HBLANK_CLOCKS+80, reflect_active <= CTRLPF[0]. The pf computed on that same edge already uses the newly latched value. CTRLPF writes at any other time do not affect the right half until the next line's latch point.
- Bit index:
  - b < 20: idx = b.
  - b >= 20: idx = reflect_active ? 39-b : b-20.
- Bit map:
  - idx 0..3 -> PF0[4+idx].
  - idx 4..11 -> PF1[11-idx].
  - idx 12..19 -> PF2[idx-12].
- pf <= hblank_next ? 0 : selected bit.
- Each playfield bit spans exactly 4 consecutive visible clocks.
- line_start asserted while hcount is already 0 keeps hcount at 0 (no glitch); line_start with en=0 is ignored.

Test Plan:
- Reset, then 228 en pulses with all regs 0 -> pf=0 throughout; hblank=1 for hcount 0..67 and 0 for 68..227; hcount wraps 227->0.
- Write PF0=0x10, reflect=0 -> pf=1 at hcount 68..71 and 148..151 only; side=1 from hcount 148.
- Write PF0=0x10, reflect=1 -> pf=1 at hcount 68..71 and 224..227 only.
- PF1=0x80, PF2=0x80, reflect=0 -> pf=1 at hcount 84..87 and 144..147 (left half), and 164..167 and 224..227 (right half).
- Set CTRLPF=1 with the write at hcount 150, PF0=0x10 -> that line's right half is unreflected (pf at 148..151); the next line is reflected (pf at 224..227).
- Assert rl low at hcount 100 with pf=1 -> pf=0, hblank=1, hcount=0 immediately; line_start pulse mid-line -> hcount=0 on the next en edge.
